// File: rtl/i2s_tx_scheduler_if.sv
// Sample-source handshake bundle: two producers offering L/R pairs to the I2S sequencer.
interface i2s_tx_scheduler_if;
  logic        SRC0_VALID;
  logic [15:0] SRC0_L;
  logic [15:0] SRC0_R;
  logic        SRC0_ACK;
  logic        SRC1_VALID;
  logic [15:0] SRC1_L;
  logic [15:0] SRC1_R;
  logic        SRC1_ACK;

  modport master (
    output SRC0_VALID, SRC0_L, SRC0_R, SRC1_VALID, SRC1_L, SRC1_R,
    input  SRC0_ACK, SRC1_ACK
  );

  modport slave (
    input  SRC0_VALID, SRC0_L, SRC0_R, SRC1_VALID, SRC1_L, SRC1_R,
    output SRC0_ACK, SRC1_ACK
  );
endinterface

// File: rtl/i2s_tx_scheduler.sv
// Master-mode I2S transmitter: derives BCLK/WCLK from MCLK, serialises 16-bit L/R
// pairs and arbitrates one of two sources per frame with fallback and underrun count.
module i2s_tx_scheduler #(
  parameter int unsigned MCLK_PER_BCLK = 4,
  parameter int unsigned SLOT_BCLKS    = 32
) (
  input  logic                      AUDIO_MCLK,
  input  logic                      RESET,
  input  logic                      ENABLE,
  input  logic                      SRC_SEL,
  i2s_tx_scheduler_if.slave         SRC,
  output logic                      AUDIO_BCLK,
  output logic                      AUDIO_WCLK,
  output logic                      SDATA_OUT,
  output logic                      FRAME_START,
  output logic                      GRANT,
  output logic                      UNDERRUN,
  output logic [7:0]                UNDERRUN_CNT,
  output logic                      BUSY
);
  localparam int unsigned DIV_W = $clog2(MCLK_PER_BCLK);
  localparam int unsigned BIT_W = $clog2(SLOT_BCLKS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t             r_state, w_state_nxt;
  logic [DIV_W-1:0]   r_div;
  logic [BIT_W-1:0]   r_bit;
  logic               r_wclk;
  logic [15:0]        r_held_l, r_held_r;
  logic               r_grant;
  logic [7:0]         r_ucnt;

  logic               w_bit_tick, w_frame_end, w_load, w_run;
  logic               w_pref_valid, w_alt_valid, w_any, w_pick;
  logic [15:0]        w_slot;
  logic [BIT_W-1:0]   w_idx;

  assign w_run        = (r_state != S_IDLE);
  assign w_bit_tick   = (r_div == DIV_W'(MCLK_PER_BCLK - 1));
  assign w_frame_end  = r_wclk && (r_bit == BIT_W'(SLOT_BCLKS - 1)) && w_bit_tick;
  assign w_pref_valid = SRC_SEL ? SRC.SRC1_VALID : SRC.SRC0_VALID;
  assign w_alt_valid  = SRC_SEL ? SRC.SRC0_VALID : SRC.SRC1_VALID;
  assign w_any        = w_pref_valid || w_alt_valid;
  assign w_pick       = w_pref_valid ? SRC_SEL : ~SRC_SEL;

  // Dropping ENABLE mid-frame drains immediately; a drop on the load cycle itself
  // skips the load and drains the following frame.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ENABLE) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (!ENABLE)          w_state_nxt = S_DRAIN;
        else if (w_frame_end) w_load      = 1'b1;
      end
      S_DRAIN: begin
        if (w_frame_end) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (RESET) w_load = 1'b0;
  end

  always_ff @(posedge AUDIO_MCLK) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge AUDIO_MCLK) begin
    if (RESET) begin
      r_div    <= '0;
      r_bit    <= '0;
      r_wclk   <= 1'b0;
      r_held_l <= '0;
      r_held_r <= '0;
      r_grant  <= 1'b0;
      r_ucnt   <= '0;
    end else begin
      if (w_run) begin
        if (w_bit_tick) begin
          r_div <= '0;
          if (r_bit == BIT_W'(SLOT_BCLKS - 1)) begin
            r_bit  <= '0;
            r_wclk <= ~r_wclk;
          end else begin
            r_bit <= r_bit + BIT_W'(1);
          end
        end else begin
          r_div <= r_div + DIV_W'(1);
        end
      end
      if (w_load && w_any) begin
        r_held_l <= w_pick ? SRC.SRC1_L : SRC.SRC0_L;
        r_held_r <= w_pick ? SRC.SRC1_R : SRC.SRC0_R;
        r_grant  <= w_pick;
      end else if (w_load && (r_ucnt != 8'hFF)) begin
        r_ucnt <= r_ucnt + 8'd1;
      end
    end
  end

  assign w_slot = r_wclk ? r_held_r : r_held_l;
  assign w_idx  = BIT_W'(16) - r_bit;

  always_comb begin
    SDATA_OUT = 1'b0;
    if (w_run && (r_bit >= BIT_W'(1)) && (r_bit <= BIT_W'(16)))
      SDATA_OUT = w_slot[w_idx[3:0]];
  end

  assign AUDIO_BCLK   = w_run && (r_div >= DIV_W'(MCLK_PER_BCLK / 2));
  assign AUDIO_WCLK   = r_wclk;
  assign FRAME_START  = w_run && (r_div == '0) && (r_bit == '0) && !r_wclk;
  assign GRANT        = r_grant;
  assign UNDERRUN     = w_load && !w_any;
  assign UNDERRUN_CNT = r_ucnt;
  assign BUSY         = w_run;
  assign SRC.SRC0_ACK = w_load && w_any && !w_pick;
  assign SRC.SRC1_ACK = w_load && w_any && w_pick;
endmodule

// File: tb/tb_i2s_tx_scheduler.sv
// Randomised bench for i2s_tx_scheduler against a frame-position reference model.
module tb_i2s_tx_scheduler;
  localparam int M     = 4;
  localparam int S     = 17;
  localparam int FRAME = 2 * M * S;

  logic       clk = 1'b0;
  logic       rst, en, sel;
  logic       bclk, wclk, sdata, fstart, grant, urun, busy;
  logic [7:0] ucnt;

  i2s_tx_scheduler_if u_if ();

  i2s_tx_scheduler #(
    .MCLK_PER_BCLK (M),
    .SLOT_BCLKS    (S)
  ) u_dut (
    .AUDIO_MCLK   (clk),
    .RESET        (rst),
    .ENABLE       (en),
    .SRC_SEL      (sel),
    .SRC          (u_if),
    .AUDIO_BCLK   (bclk),
    .AUDIO_WCLK   (wclk),
    .SDATA_OUT    (sdata),
    .FRAME_START  (fstart),
    .GRANT        (grant),
    .UNDERRUN     (urun),
    .UNDERRUN_CNT (ucnt),
    .BUSY         (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // model: mode 0 idle, 1 run, 2 drain; m_t = MCLK cycles since frame start
  int          m_mode = 0;
  int          m_t    = 0;
  logic [15:0] m_l    = '0;
  logic [15:0] m_r    = '0;
  logic        m_grant = 1'b0;
  int          m_ucnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic step();
    logic [8:0]  exp_v, got_v;
    logic [15:0] smp;
    int          bitn;
    logic        act, load, any, g, sd;
    #1;
    act  = (m_mode != 0);
    bitn = (m_t / M) % S;
    smp  = (m_t >= M * S) ? m_r : m_l;
    sd   = 1'b0;
    if (act && bitn >= 1 && bitn <= 16) sd = smp[16 - bitn];
    load = !rst && en && ((m_mode == 0) || (m_mode == 1 && m_t == FRAME - 1));
    any  = u_if.SRC0_VALID || u_if.SRC1_VALID;
    g    = (sel ? u_if.SRC1_VALID : u_if.SRC0_VALID) ? sel : ~sel;
    exp_v = {act, act && (m_t % M) >= M / 2, act && m_t >= M * S, sd,
             act && m_t == 0, m_grant, load && !any, load && any && !g, load && any && g};
    got_v = {busy, bclk, wclk, sdata, fstart, grant, urun, u_if.SRC0_ACK, u_if.SRC1_ACK};
    check_eq("outs{busy,bclk,wclk,sd,fs,gnt,urun,ack0,ack1}", 32'(got_v), 32'(exp_v));
    check_eq("underrun_cnt", 32'(ucnt), 32'(m_ucnt));
    if (rst) begin
      m_mode = 0; m_t = 0; m_l = '0; m_r = '0; m_grant = 1'b0; m_ucnt = 0;
    end else begin
      if (load && any) begin
        m_l     = g ? u_if.SRC1_L : u_if.SRC0_L;
        m_r     = g ? u_if.SRC1_R : u_if.SRC0_R;
        m_grant = g;
      end else if (load && m_ucnt < 255) begin
        m_ucnt++;
      end
      case (m_mode)
        0: if (en) begin m_mode = 1; m_t = 0; end
        1: begin if (!en) m_mode = 2; m_t = (m_t + 1) % FRAME; end
        default: begin if (m_t == FRAME - 1) m_mode = 0; m_t = (m_t + 1) % FRAME; end
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Advance until the model is running at frame position t (bounded).
  task automatic wait_pos(input int t);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      if (m_mode == 1 && m_t == t) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check_eq("wait_pos_reached", 32'(found), 32'd1);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; sel = 1'b0;
    u_if.SRC0_VALID = 1'b0; u_if.SRC0_L = '0; u_if.SRC0_R = '0;
    u_if.SRC1_VALID = 1'b0; u_if.SRC1_L = '0; u_if.SRC1_R = '0;
    @(posedge clk);
    #1;
    run(2);
    rst = 1'b0;

    u_if.SRC0_VALID = 1'b1; u_if.SRC0_L = 16'hA5C3; u_if.SRC0_R = 16'h3C5A;
    run(2 * FRAME + 2);

    u_if.SRC0_VALID = 1'b0;
    u_if.SRC1_VALID = 1'b1; u_if.SRC1_L = 16'h8001; u_if.SRC1_R = 16'h7FFE;
    run(2 * FRAME);

    for (int i = 0; i < 20 * FRAME; i++) begin
      u_if.SRC0_VALID = ($urandom_range(0, 3) != 0);
      u_if.SRC1_VALID = ($urandom_range(0, 2) == 0);
      u_if.SRC0_L = 16'($urandom); u_if.SRC0_R = 16'($urandom);
      u_if.SRC1_L = 16'($urandom); u_if.SRC1_R = 16'($urandom);
      sel = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 199) == 0) en = ~en;
      step();
    end
    en = 1'b1;
    u_if.SRC0_VALID = 1'b1; u_if.SRC1_VALID = 1'b1;

    wait_pos(M * S + 10 * M + 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("busy_after_reset", 32'(busy), 32'd0);
    run(FRAME + 4);

    sel = 1'b1;
    u_if.SRC0_VALID = 1'b0;
    u_if.SRC1_L = 16'h1234; u_if.SRC1_R = 16'h1234;
    wait_pos(FRAME - 1);
    step();
    u_if.SRC1_VALID = 1'b0;
    run(260 * FRAME);
    check_eq("underrun_cnt_saturated", 32'(ucnt), 32'd255);

    u_if.SRC0_VALID = 1'b1; u_if.SRC0_L = 16'h0F0F; u_if.SRC0_R = 16'hF0F0;
    wait_pos(5 * M + 1);
    en = 1'b0;
    run(FRAME + 8);
    check_eq("busy_after_drain", 32'(busy), 32'd0);
    check_eq("bclk_after_drain", 32'(bclk), 32'd0);

    en = 1'b1;
    wait_pos(FRAME - 1);
    en = 1'b0;
    run(2 * FRAME + 4);
    check_eq("busy_after_load_drain", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/i2s_tx_scheduler.md
Name: i2s_tx_scheduler

Overview:
Master-mode I2S transmit sequencer for the audio codec path. It divides AUDIO_MCLK into AUDIO_BCLK and AUDIO_WCLK and serialises 16-bit left/right samples onto SDATA_OUT. It shares the single DAC slot pair between two sample sources (line-in passthrough and mic/sine generator) using a per-frame valid/ack handshake with fallback and underrun handling.

Parameters:
MCLK_PER_BCLK, 4, AUDIO_MCLK cycles per BCLK period; even, >=2.
SLOT_BCLKS, 32, BCLK periods per channel slot; >=17.

Ports:
AUDIO_MCLK  input  1  sole clock; all logic on posedge.
RESET  input  1  synchronous, active-high reset.
ENABLE  input  1  run request; 0 stops at the next frame boundary.
SRC_SEL  input  1  preferred source: 0 = source 0, 1 = source 1.
SRC0_VALID  input  1  source 0 has a sample pair ready.
SRC0_L  input  16  source 0 left sample, two's complement.
SRC0_R  input  16  source 0 right sample.
SRC0_ACK  output  1  one-cycle pulse: source 0 pair consumed.
SRC1_VALID  input  1  source 1 has a sample pair ready.
SRC1_L  input  16  source 1 left sample.
SRC1_R  input  16  source 1 right sample.
SRC1_ACK  output  1  one-cycle pulse: source 1 pair consumed.
AUDIO_BCLK  output  1  bit clock to codec.
AUDIO_WCLK  output  1  word clock; 0 = left slot, 1 = right slot.
SDATA_OUT  output  1  serial data, MSB first.
FRAME_START  output  1  one-cycle pulse at the start of each left slot.
GRANT  output  1  source that supplied the current frame.
UNDERRUN  output  1  one-cycle pulse: no source valid at load.
UNDERRUN_CNT  output  8  saturating underrun count.
BUSY  output  1  1 in RUN or DRAIN.

Behaviour:
- Reset (RESET=1 at a posedge): state IDLE; all counters, held samples, GRANT and UNDERRUN_CNT = 0; every output 0. Reset overrides everything, including mid-frame.
- States:
  - IDLE: BCLK, WCLK and SDATA held 0. ENABLE=1 -> RUN. The transition cycle is a load cycle.
  - RUN: free-running timing. At a load cycle with ENABLE=0 -> DRAIN with no load. On entering DRAIN, the frame in progress completes.
  - DRAIN: completes the current frame. At the last cycle of right-slot bit SLOT_BCLKS-1 -> IDLE; no ACK is issued.
- Divider: div counts 0..MCLK_PER_BCLK-1. BCLK = 0 while div < MCLK_PER_BCLK/2, else 1.
- Bit tick: the cycle where div wraps to 0 (BCLK falling edge). bit_cnt advances on each bit tick, 0..SLOT_BCLKS-1. On wrap, WCLK toggles.
- SDATA changes only on falling BCLK:
  - slot bit k = 1..16: SDATA = held_sample[16-k], where held_sample is the left register when WCLK=0 and the right register when WCLK=1.
  - bit 0 and bits 17..SLOT_BCLKS-1: SDATA = 0.
- Load cycle: the IDLE->RUN cycle, or the RUN cycle with WCLK=1, bit_cnt=SLOT_BCLKS-1 and div=MCLK_PER_BCLK-1.
- Arbitration at a load cycle (VALIDs are sampled only here):
  - Preferred source valid -> load its L/R, pulse its ACK, GRANT = preferred.
  - Else other source valid -> load it, pulse its ACK, GRANT = other.
  - Else: held samples and GRANT unchanged; pulse UNDERRUN; UNDERRUN_CNT +1, saturating at 255.
  - Never both ACKs in the same cycle.
- FRAME_START pulses on the first cycle of each left slot (bit_cnt=0, WCLK=0, div=0), including the first frame after IDLE.
- Latency: the first frame after ENABLE rises starts on the cycle after the load cycle. Left bit 1 appears after 1 BCLK period (MCLK_PER_BCLK cycles).
- ENABLE=0 on the exact load cycle: no load, no ACK, enter DRAIN. The frame in progress finishes, then IDLE.
- SRC_SEL changes take effect only at the next load cycle.

Test Plan:
- Reset: RESET=1 for 2 cycles, ENABLE=1 -> BCLK/WCLK/SDATA/ACKs/UNDERRUN_CNT = 0. RUN is entered the cycle after RESET falls.
- Basic frame (defaults): SRC0_VALID=1, L=16'hA5C3, R=16'h3C5A, SRC_SEL=0.
  - SRC0_ACK pulses on the load cycle.
  - BCLK period is 4 MCLK; WCLK toggles every 128 MCLK.
  - Left bits 1..16 = 1010010111000011; bits 0 and 17..31 = 0.
  - Right slot carries 0011110001011010.
- Fallback: SRC_SEL=0, SRC0_VALID=0, SRC1_VALID=1 with L=16'h8001 -> SRC1_ACK pulses only, GRANT=1, left bit 1 = 1 and bit 16 = 1.
- Underrun: both VALIDs=0 for 300 frames after one 16'h1234 pair.
  - Every frame repeats 16'h1234.
  - UNDERRUN pulses once per frame.
  - UNDERRUN_CNT stops at 255.
- Drain: drop ENABLE during left bit 5.
  - The frame completes through right bit 31.
  - No ACK is issued; IDLE follows and BUSY=0.
  - BCLK then stays 0.
- Reset mid-frame: RESET=1 during right bit 10 -> all outputs 0 the next cycle.
  - With ENABLE=1, a fresh frame starts with a new load and ACK.
